me_batch_sched: RTL and testbench

Batch scheduler that sequences the `me_double` motion-estimation engine over a run of macroblocks. It drives the engine's four-phase `req`/`ack` handshake once per block and publishes `blk_idx` so the search-window and template loaders select the right block. Each block's `min_sad`/`min_mvec` result is captured into a small result FIFO. The block also tracks the best SAD in the batch and supervises the engine with a per-block timeout.

---
 rtl/me_batch_sched.sv | 183 ++++++++++++++++++
 tb/tb_me_batch_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_batch_sched.sv
// Batch scheduler for the me_double engine: issues one four-phase req/ack per
// block, queues each block's result, tracks the batch minimum SAD and times out a stuck engine.
module me_batch_sched #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  num_blk,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  blk_idx,
   output logic        me_req,
   input  logic        me_ack,
   input  logic [15:0] me_min_sad,
   input  logic [9:0]  me_min_mvec,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_sad,
   output logic [9:0]  res_mvec,
   output logic [7:0]  res_idx,
   output logic [15:0] best_sad,
   output logic [7:0]  best_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_RELEASE, S_DRAIN, S_DONE
   } state_t;

   state_t          state, next_state;
   logic [7:0]      num_lat;
   logic [15:0]     to_cnt;
   logic [CW-1:0]   count;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [15:0]     fifo_sad  [DEPTH];
   logic [9:0]      fifo_mvec [DEPTH];
   logic [7:0]      fifo_idx  [DEPTH];

   logic space_free, timeout, last_blk, push, pop;
   logic next_req, accept, blk_inc, to_fire;

   // Only one request is ever outstanding, so a free slot at issue time is a reservation.
   assign space_free = (count < CW'(DEPTH));
   assign timeout    = (to_cnt == 16'(TIMEOUT - 1));
   assign last_blk   = (blk_idx == num_lat - 8'd1);
   assign pop        = res_valid & res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      next_req   = me_req;
      accept     = 1'b0;
      blk_inc    = 1'b0;
      push       = 1'b0;
      to_fire    = 1'b0;
      case (state)
         S_IDLE: if (start) begin
            accept = 1'b1;
            if (num_blk == 8'd0) next_state = S_DONE;
            else if (space_free) begin
               next_state = S_WAIT_ACK;
               next_req   = 1'b1;
            end else next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (abort) begin
               next_state = S_DRAIN;
               next_req   = 1'b0;
            end else if (space_free) begin
               next_state = S_WAIT_ACK;
               next_req   = 1'b1;
            end
         end
         S_WAIT_ACK: begin
            // Abort wins over a coincident ack; that result is dropped.
            if (abort) begin
               next_state = S_DRAIN;
               next_req   = 1'b0;
            end else if (me_ack) begin
               push       = 1'b1;
               next_state = S_RELEASE;
               next_req   = 1'b0;
            end else if (timeout) begin
               to_fire    = 1'b1;
               next_state = S_DRAIN;
               next_req   = 1'b0;
            end
         end
         S_RELEASE: begin
            if (abort) begin
               next_state = S_DRAIN;
               next_req   = 1'b0;
            end else if (!me_ack) begin
               if (last_blk) next_state = S_DONE;
               else begin
                  blk_inc = 1'b1;
                  if (space_free) begin
                     next_state = S_WAIT_ACK;
                     next_req   = 1'b1;
                  end else next_state = S_ISSUE;
               end
            end
         end
         S_DRAIN: if (!me_ack) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         me_req   <= 1'b0;
         blk_idx  <= 8'd0;
         num_lat  <= 8'd0;
         err      <= 1'b0;
         best_sad <= 16'hFFFF;
         best_idx <= 8'd0;
         to_cnt   <= 16'd0;
      end else begin
         me_req <= next_req;
         if (accept) begin
            err      <= 1'b0;
            num_lat  <= num_blk;
            blk_idx  <= 8'd0;
            best_sad <= 16'hFFFF;
            best_idx <= 8'd0;
         end
         if (blk_inc) blk_idx <= blk_idx + 8'd1;
         if (to_fire) err <= 1'b1;
         if (push && (me_min_sad < best_sad)) begin
            best_sad <= me_min_sad;
            best_idx <= blk_idx;
         end
         if (next_state == S_WAIT_ACK && state != S_WAIT_ACK) to_cnt <= 16'd0;
         else if (state == S_WAIT_ACK)                      to_cnt <= to_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; emptiness lives in count and the outputs are masked by it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_sad[wr_ptr]  <= me_min_sad;
         fifo_mvec[wr_ptr] <= me_min_mvec;
         fifo_idx[wr_ptr]  <= blk_idx;
      end
   end

   assign res_valid = (count != '0);
   assign res_sad   = res_valid ? fifo_sad[rd_ptr]  : 16'd0;
   assign res_mvec  = res_valid ? fifo_mvec[rd_ptr] : 10'd0;
   assign res_idx   = res_valid ? fifo_idx[rd_ptr]  : 8'd0;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_me_batch_sched.sv
// Self-checking bench for me_batch_sched: engine/consumer model on the falling edge,
// result scoreboard, table-driven batches and hand-written corner sequences.
module tb_me_batch_sched;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_blk = 8'd0;
   logic        abort;
   logic        busy, done, err, me_req, res_valid;
   logic [7:0]  blk_idx, res_idx, best_idx;
   logic        me_ack, res_ready;
   logic [15:0] me_min_sad, res_sad, best_sad;
   logic [9:0]  me_min_mvec, res_mvec;

   me_batch_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_blk(num_blk), .abort(abort),
      .busy(busy), .done(done), .err(err), .blk_idx(blk_idx), .me_req(me_req),
      .me_ack(me_ack), .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
      .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad),
      .res_mvec(res_mvec), .res_idx(res_idx), .best_sad(best_sad), .best_idx(best_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] sad;
      logic [9:0]  mvec;
      logic [7:0]  idx;
   } res_t;

   typedef struct {
      int          nblk;
      int          lat;
      logic [15:0] s0, s1, s2, s3;
      logic [15:0] exp_best_sad;
      logic [7:0]  exp_best_idx;
   } vec_t;

   res_t        sb[$];
   int          n_checks = 0, n_errors = 0;
   int          done_cnt = 0, req_cnt = 0, pops = 0;
   bit          eng_en = 1'b0, cons_en = 1'b0;
   int          eng_lat = 0, eng_hold = 0, abort_blk = -1;
   logic [15:0] sad_tab [16];
   int          eng_blk = 0, lat_cnt = 0, hold_cnt = 0;
   logic        req_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   function automatic logic [9:0] mv_of(input int b);
      return 10'(b * 37 + 5);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Engine, consumer and event monitor all act on the falling edge.
   initial begin
      res_t e;
      me_ack = 1'b0; abort = 1'b0; res_ready = 1'b0;
      me_min_sad = 16'd0; me_min_mvec = 10'd0;
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (me_req && !req_prev) req_cnt++;
         req_prev = me_req;
         if (!rst_n) begin
            sb.delete();
            me_ack = 1'b0; abort = 1'b0; res_ready = 1'b0;
            eng_blk = 0; lat_cnt = 0; hold_cnt = 0;
         end else begin
            if (start && !busy) eng_blk = 0;
            abort = 1'b0;
            res_ready = cons_en;
            if (res_valid && res_ready) begin
               if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
               else begin
                  e = sb.pop_front();
                  check("res_sad", res_sad, e.sad);
                  check("res_mvec", res_mvec, e.mvec);
                  check("res_idx", res_idx, e.idx);
                  pops++;
               end
            end
            if (!eng_en) me_ack = 1'b0;
            else if (me_ack) begin
               if (!me_req) begin
                  if (hold_cnt >= eng_hold) me_ack = 1'b0;
                  else hold_cnt++;
               end
            end else if (me_req) begin
               if (lat_cnt >= eng_lat) begin
                  me_ack = 1'b1; hold_cnt = 0; lat_cnt = 0;
                  me_min_sad  = sad_tab[eng_blk];
                  me_min_mvec = mv_of(eng_blk);
                  check("ack_blk_idx", blk_idx, eng_blk);
                  if (eng_blk == abort_blk) abort = 1'b1;
                  else sb.push_back('{sad: sad_tab[eng_blk], mvec: mv_of(eng_blk), idx: 8'(eng_blk)});
                  eng_blk++;
               end else lat_cnt++;
            end else lat_cnt = 0;
         end
      end
   end

   task automatic begin_batch(input int n);
      start = 1'b1;
      num_blk = 8'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int k = 0;
      while (done_cnt == d0 && k < limit) begin
         tick();
         k++;
      end
      if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_batch(input int n);
      int d0;
      d0 = done_cnt;
      begin_batch(n);
      check("start_busy", busy, 1'b1);
      check("start_req", me_req, 1'b1);
      check("start_err_clr", err, 1'b0);
      wait_done(d0, 3000);
      tick();
      check("end_busy", busy, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err"}, err, 1'b0);
      check({tag, "_req"}, me_req, 1'b0);
      check({tag, "_blk_idx"}, blk_idx, 8'd0);
      check({tag, "_res_valid"}, res_valid, 1'b0);
      check({tag, "_res_sad"}, res_sad, 16'd0);
      check({tag, "_res_mvec"}, res_mvec, 10'd0);
      check({tag, "_res_idx"}, res_idx, 8'd0);
      check({tag, "_best_sad"}, best_sad, 16'hFFFF);
      check({tag, "_best_idx"}, best_idx, 8'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   vec_t vecs [4];
   int d0, r0, p0, n;

   initial begin
      vecs[0] = '{3, 20, 16'd500, 16'd120, 16'd300, 16'd0,   16'd120,   8'd1};
      vecs[1] = '{2, 3,  16'd200, 16'd200, 16'd0,   16'd0,   16'd200,   8'd0};
      vecs[2] = '{4, 1,  16'd900, 16'd800, 16'd800, 16'd50,  16'd50,    8'd3};
      vecs[3] = '{1, 0,  16'hFFFF, 16'd0,  16'd0,   16'd0,   16'hFFFF,  8'd0};

      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      eng_en = 1'b1;
      cons_en = 1'b1;
      tick();

      // Zero-length batch: a done pulse, no request ever.
      d0 = done_cnt; r0 = req_cnt;
      begin_batch(0);
      check("zero_busy", busy, 1'b1);
      repeat (3) tick();
      check("zero_done_cnt", done_cnt - d0, 1);
      check("zero_req_cnt", req_cnt - r0, 0);
      check("zero_busy_end", busy, 1'b0);

      // Timeout: engine silent, request must drop after TIMEOUT cycles.
      eng_en = 1'b0;
      d0 = done_cnt; p0 = pops;
      begin_batch(2);
      check("to_req_up", me_req, 1'b1);
      n = 0;
      while (me_req && n < 200) begin
         n++;
         tick();
      end
      check("to_req_cycles", n, TIMEOUT);
      check("to_err", err, 1'b1);
      wait_done(d0, 10);
      tick();
      check("to_done_cnt", done_cnt - d0, 1);
      check("to_fifo_empty", res_valid, 1'b0);
      check("to_err_sticky", err, 1'b1);
      eng_en = 1'b1;

      // Table of normal batches with a ready consumer.
      for (int v = 0; v < 4; v++) begin
         sad_tab[0] = vecs[v].s0; sad_tab[1] = vecs[v].s1;
         sad_tab[2] = vecs[v].s2; sad_tab[3] = vecs[v].s3;
         eng_lat = vecs[v].lat;
         d0 = done_cnt; r0 = req_cnt; p0 = pops;
         run_batch(vecs[v].nblk);
         repeat (4) tick();
         check($sformatf("v%0d_best_sad", v), best_sad, vecs[v].exp_best_sad);
         check($sformatf("v%0d_best_idx", v), best_idx, vecs[v].exp_best_idx);
         check($sformatf("v%0d_err", v), err, 1'b0);
         check($sformatf("v%0d_done_cnt", v), done_cnt - d0, 1);
         check($sformatf("v%0d_req_cnt", v), req_cnt - r0, vecs[v].nblk);
         check($sformatf("v%0d_pops", v), pops - p0, vecs[v].nblk);
         check($sformatf("v%0d_sb_empty", v), sb.size(), 0);
      end

      // Start while busy is ignored.
      sad_tab[0] = 16'd70; sad_tab[1] = 16'd60;
      eng_lat = 10;
      d0 = done_cnt; r0 = req_cnt;
      begin_batch(2);
      repeat (5) tick();
      begin_batch(9);
      wait_done(d0, 500);
      repeat (4) tick();
      check("busy_start_req_cnt", req_cnt - r0, 2);
      check("busy_start_done_cnt", done_cnt - d0, 1);
      check("busy_start_best_idx", best_idx, 8'd1);
      check("busy_start_busy", busy, 1'b0);

      // Backpressure: a full FIFO stalls issue until the consumer drains.
      for (int i = 0; i < 6; i++) sad_tab[i] = 16'(100 + i * 11);
      eng_lat = 2;
      cons_en = 1'b0;
      d0 = done_cnt; r0 = req_cnt; p0 = pops;
      begin_batch(6);
      repeat (150) tick();
      check("bp_req_cnt_stall", req_cnt - r0, DEPTH);
      check("bp_req_low", me_req, 1'b0);
      check("bp_busy", busy, 1'b1);
      check("bp_blk_idx", blk_idx, 8'd4);
      check("bp_valid", res_valid, 1'b1);
      cons_en = 1'b1;
      wait_done(d0, 500);
      repeat (4) tick();
      check("bp_req_cnt", req_cnt - r0, 6);
      check("bp_pops", pops - p0, 6);
      check("bp_sb_empty", sb.size(), 0);
      check("bp_best_sad", best_sad, 16'd100);

      // Abort coincident with ack on block 1 of 4.
      sad_tab[0] = 16'd333; sad_tab[1] = 16'd1;
      eng_lat = 4; eng_hold = 3; abort_blk = 1;
      cons_en = 1'b0;
      d0 = done_cnt; r0 = req_cnt; p0 = pops;
      begin_batch(4);
      n = 0;
      while (!abort && n < 200) begin
         tick();
         n++;
      end
      check("ab_seen", abort, 1'b1);
      check("ab_req_low", me_req, 1'b0);
      check("ab_busy_drain", busy, 1'b1);
      check("ab_no_done_yet", done_cnt - d0, 0);
      wait_done(d0, 50);
      tick();
      check("ab_done_cnt", done_cnt - d0, 1);
      check("ab_req_cnt", req_cnt - r0, 2);
      check("ab_head_idx", res_idx, 8'd0);
      check("ab_head_sad", res_sad, 16'd333);
      check("ab_best_sad", best_sad, 16'd333);
      check("ab_best_idx", best_idx, 8'd0);
      cons_en = 1'b1;
      repeat (4) tick();
      check("ab_pops", pops - p0, 1);
      check("ab_fifo_empty", res_valid, 1'b0);
      check("ab_sb_empty", sb.size(), 0);
      abort_blk = -1; eng_hold = 0;

      // Reset mid-batch with a request outstanding and two queued results.
      for (int i = 0; i < 5; i++) sad_tab[i] = 16'(40 + i);
      eng_lat = 30;
      cons_en = 1'b0;
      r0 = req_cnt;
      begin_batch(5);
      n = 0;
      while (!((req_cnt - r0) == 3 && me_req) && n < 500) begin
         tick();
         n++;
      end
      check("rst_pre_req", me_req, 1'b1);
      check("rst_pre_valid", res_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      cons_en = 1'b1;
      eng_lat = 3;
      sad_tab[0] = 16'd9; sad_tab[1] = 16'd8;
      d0 = done_cnt; r0 = req_cnt; p0 = pops;
      run_batch(2);
      repeat (4) tick();
      check("post_rst_req_cnt", req_cnt - r0, 2);
      check("post_rst_pops", pops - p0, 2);
      check("post_rst_best_idx", best_idx, 8'd1);
      check("post_rst_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
